bnn_image_loader: RTL

//  Responder side of the top-level FSM's LOAD handshake. While fsm_state == LOAD (3'b001),

---
 rtl/bnn_image_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bnn_image_loader.sv
// bnn_image_loader: during fsm_state == LOAD, accepts a binarized image as BUS_W-bit beats
// and packs it into a flat pixel register. Optional trailing XOR checksum beat: LOADER_CKSUM_EN.
module bnn_image_loader #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int BUS_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             fsm_state,
    input  logic [BUS_W-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [IMG_W*IMG_H-1:0] pixels,
    output logic                   pixels_valid,
    output logic                   load_done,
    output logic                   cksum_err
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NBEAT = (NPIX + BUS_W - 1) / BUS_W;
    localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [2:0]    FSM_LOAD  = 3'b001;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_CKSUM,
        S_DONE,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NPIX-1:0]   pixels_q, pixels_d;
    logic              pixels_valid_q, pixels_valid_d;
    logic [NBEAT*BUS_W-1:0] beat_buf;

    logic load_active;
    logic accept;
    logic start;

    assign load_active = (fsm_state == FSM_LOAD);
    assign accept      = in_valid && in_ready;
    assign start       = (state_q == S_IDLE) && load_active;

    // ------------------------------------------------------------------ state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------ next state
    always_comb begin
        // NOTE: defaulting state_d first keeps every path assigned, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_active) state_d = S_RECV;
            end
            S_RECV: begin
                if (!load_active) begin
                    state_d = S_IDLE;
                end else if (accept && cnt_q == LAST_BEAT) begin
`ifdef LOADER_CKSUM_EN
                    state_d = S_CKSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_CKSUM: begin
                if (!load_active)  state_d = S_IDLE;
                else if (accept)   state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!load_active) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        in_ready  = 1'b0;
        load_done = 1'b0;
        unique case (state_q)
            S_RECV:  in_ready  = 1'b1;
            S_CKSUM: in_ready  = 1'b1;
            S_DONE:  load_done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ pixel datapath
    always_comb begin
        cnt_d          = cnt_q;
        pixels_d       = pixels_q;
        pixels_valid_d = pixels_valid_q;
        beat_buf       = '0;

        if (start) begin
            cnt_d          = '0;
            pixels_valid_d = 1'b0;
        end

        // An abort (fsm_state leaving LOAD) takes priority over a beat presented that cycle.
        if (state_q == S_RECV && load_active && accept) begin
            beat_buf[NPIX-1:0]                   = pixels_q;
            beat_buf[int'(cnt_q) * BUS_W +: BUS_W] = in_data;
            pixels_d                             = beat_buf[NPIX-1:0];
            if (cnt_q != LAST_BEAT) cnt_d = cnt_q + CW'(1);
        end

        if (state_d == S_DONE) pixels_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: the pixel store is a plain register that must read 0 after reset, so it is
        // reset like any other flop rather than treated as an unreset memory.
        if (!rst_n) begin
            cnt_q          <= '0;
            pixels_q       <= '0;
            pixels_valid_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            pixels_q       <= pixels_d;
            pixels_valid_q <= pixels_valid_d;
        end
    end

    assign pixels       = pixels_q;
    assign pixels_valid = pixels_valid_q;

`ifdef LOADER_CKSUM_EN
    // ------------------------------------------------------------------ checksum
    logic [BUS_W-1:0] acc_q, acc_d;
    logic             err_q, err_d;

    always_comb begin
        acc_d = acc_q;
        err_d = err_q;
        if (start) begin
            acc_d = '0;
            err_d = 1'b0;
        end
        if (state_q == S_RECV && load_active && accept) acc_d = acc_q ^ in_data;
        if (state_q == S_CKSUM && load_active && accept && in_data != acc_q) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            err_q <= err_d;
        end
    end

    assign cksum_err = err_q;
`else
    assign cksum_err = 1'b0;
`endif

endmodule
